// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// The register captures decoded operands, instruction fields and control bits from ID
// and presents them to EX. It supports bubble insertion, flush and a global hold.
// The optional bubble counter is enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage_register #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             valid_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_data_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [4:0]       rs1_idx_in,
    input  logic [4:0]       rs2_idx_in,
    input  logic [4:0]       instruction_11_7_in,
    input  logic [2:0]       instruction_14_12_in,
    input  logic             instruction_30_in,
    input  logic [1:0]       alu_op_in,
    input  logic             alu_src_in,
    input  logic             branch_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             reg_write_in,
    input  logic             mem_to_reg_in,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [XLEN-1:0]  imm_out,
    output logic [4:0]       rs1_idx_out,
    output logic [4:0]       rs2_idx_out,
    output logic [4:0]       instruction_11_7_out,
    output logic [2:0]       instruction_14_12_out,
    output logic             instruction_30_out,
    output logic [1:0]       alu_op_out,
    output logic             alu_src_out,
    output logic             branch_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             reg_write_out,
    output logic             mem_to_reg_out,
    output logic             valid_out,
    output logic             hazard_stall_out,
    output logic [CNT_W-1:0] bubble_count_out
);

    logic hazard;
    logic capture;

    // Load-use detection: a valid load in EX writing a register the ID instruction reads
    always_comb begin
        hazard = valid_out & mem_read_out & (instruction_11_7_out != 5'd0) & valid_in
               & ((instruction_11_7_out == rs1_idx_in) | (instruction_11_7_out == rs2_idx_in));
        capture = ~flush_in & ~stall_in & ~hazard;
    end

    assign hazard_stall_out = hazard & ~flush_in & ~stall_in;

    // Data fields: load on a normal advance, otherwise hold (don't-care inside a bubble)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_out                <= '0;
            rs1_data_out          <= '0;
            rs2_data_out          <= '0;
            imm_out               <= '0;
            rs1_idx_out           <= '0;
            rs2_idx_out           <= '0;
            instruction_11_7_out  <= '0;
            instruction_14_12_out <= '0;
            instruction_30_out    <= 1'b0;
        end else if (capture) begin
            pc_out                <= pc_in;
            rs1_data_out          <= rs1_data_in;
            rs2_data_out          <= rs2_data_in;
            imm_out               <= imm_in;
            rs1_idx_out           <= rs1_idx_in;
            rs2_idx_out           <= rs2_idx_in;
            instruction_11_7_out  <= instruction_11_7_in;
            instruction_14_12_out <= instruction_14_12_in;
            instruction_30_out    <= instruction_30_in;
        end
    end

    // Valid and control bits: flush beats stall, stall beats hazard bubble
    always_ff @(posedge CLK) begin
        if (RESET || flush_in || (!stall_in && hazard)) begin
            valid_out      <= 1'b0;
            alu_op_out     <= '0;
            alu_src_out    <= 1'b0;
            branch_out     <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
        end else if (!stall_in) begin
            valid_out      <= valid_in;
            alu_op_out     <= valid_in ? alu_op_in : 2'b00;
            alu_src_out    <= valid_in & alu_src_in;
            branch_out     <= valid_in & branch_in;
            mem_read_out   <= valid_in & mem_read_in;
            mem_write_out  <= valid_in & mem_write_in;
            reg_write_out  <= valid_in & reg_write_in;
            mem_to_reg_out <= valid_in & mem_to_reg_in;
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic bubble;
    assign bubble = flush_in | (~stall_in & hazard);

    // Saturating count of inserted bubbles (flush or hazard), cleared only by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bubble_count_out <= '0;
        end else if (bubble && (bubble_count_out != '1)) begin
            bubble_count_out <= bubble_count_out + CNT_W'(1);
        end
    end
`else
    assign bubble_count_out = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for id_ex_stage_register: expected register contents are queued when
// each step is driven and compared after the following rising edge.
module tb_id_ex_stage_register;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1i, rs2i, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  aop;
        logic        asrc, br, mr, mw, rw, m2r, v;
    } st_t;

    typedef struct packed {
        st_t              s;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic CLK, RESET, stall_in, flush_in, valid_in;
    logic [XLEN-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
    logic [4:0] rs1_idx_in, rs2_idx_in, instruction_11_7_in;
    logic [2:0] instruction_14_12_in;
    logic instruction_30_in;
    logic [1:0] alu_op_in;
    logic alu_src_in, branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic [XLEN-1:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
    logic [4:0] rs1_idx_out, rs2_idx_out, instruction_11_7_out;
    logic [2:0] instruction_14_12_out;
    logic instruction_30_out;
    logic [1:0] alu_op_out;
    logic alu_src_out, branch_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
    logic valid_out, hazard_stall_out;
    logic [CNT_W-1:0] bubble_count_out;

    int tests = 0;
    int fails = 0;
    st_t m = '0;
    logic [CNT_W-1:0] mc = '0;
    exp_t q[$];

    id_ex_stage_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
        .rs1_idx_in(rs1_idx_in), .rs2_idx_in(rs2_idx_in),
        .instruction_11_7_in(instruction_11_7_in), .instruction_14_12_in(instruction_14_12_in),
        .instruction_30_in(instruction_30_in), .alu_op_in(alu_op_in), .alu_src_in(alu_src_in),
        .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .pc_out(pc_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
        .rs1_idx_out(rs1_idx_out), .rs2_idx_out(rs2_idx_out),
        .instruction_11_7_out(instruction_11_7_out), .instruction_14_12_out(instruction_14_12_out),
        .instruction_30_out(instruction_30_out), .alu_op_out(alu_op_out), .alu_src_out(alu_src_out),
        .branch_out(branch_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .valid_out(valid_out),
        .hazard_stall_out(hazard_stall_out), .bubble_count_out(bubble_count_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic st_t obs();
        st_t o;
        o = '{pc: pc_out, rs1d: rs1_data_out, rs2d: rs2_data_out, imm: imm_out,
              rs1i: rs1_idx_out, rs2i: rs2_idx_out, rd: instruction_11_7_out,
              f3: instruction_14_12_out, f7: instruction_30_out, aop: alu_op_out,
              asrc: alu_src_out, br: branch_out, mr: mem_read_out, mw: mem_write_out,
              rw: reg_write_out, m2r: mem_to_reg_out, v: valid_out};
        return o;
    endfunction

    function automatic st_t rnd();
        st_t r;
        r = '0;
        r.pc = $urandom; r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom;
        r.rs1i = 5'($urandom_range(10, 31)); r.rs2i = 5'($urandom_range(10, 31));
        r.rd = 5'($urandom_range(10, 31)); r.f3 = 3'($urandom); r.f7 = 1'($urandom);
        return r;
    endfunction

    function automatic st_t kill(input st_t s);
        st_t k;
        k = s;
        k.aop = 2'b00; k.asrc = 1'b0; k.br = 1'b0; k.mr = 1'b0;
        k.mw = 1'b0; k.rw = 1'b0; k.m2r = 1'b0; k.v = 1'b0;
        return k;
    endfunction

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input st_t d);
        pc_in = d.pc; rs1_data_in = d.rs1d; rs2_data_in = d.rs2d; imm_in = d.imm;
        rs1_idx_in = d.rs1i; rs2_idx_in = d.rs2i; instruction_11_7_in = d.rd;
        instruction_14_12_in = d.f3; instruction_30_in = d.f7; alu_op_in = d.aop;
        alu_src_in = d.asrc; branch_in = d.br; mem_read_in = d.mr; mem_write_in = d.mw;
        reg_write_in = d.rw; mem_to_reg_in = d.m2r; valid_in = d.v;
    endtask

    // One clock: drive, optionally check the combinational stall, queue the expected
    // register image, then compare it after the edge.
    task automatic step(input st_t d, input logic rst, input logic stl, input logic fl,
                        input logic chk_hz);
        logic hz;
        logic bub;
        exp_t e;
        RESET = rst; stall_in = stl; flush_in = fl;
        drive(d);
        #1;
        hz = m.v & m.mr & (m.rd != 5'd0) & d.v & ((m.rd == d.rs1i) | (m.rd == d.rs2i));
        if (chk_hz) check("hazard_stall", 192'(hazard_stall_out), 192'(hz & ~fl & ~stl));
        bub = 1'b0;
        if (rst) e.s = '0;
        else if (fl) begin e.s = kill(m); bub = 1'b1; end
        else if (stl) e.s = m;
        else if (hz) begin e.s = kill(m); bub = 1'b1; end
        else e.s = d.v ? d : kill(d);
`ifdef ID_EX_BUBBLE_COUNT_EN
        if (rst) e.cnt = '0;
        else if (bub && mc != '1) e.cnt = mc + CNT_W'(1);
        else e.cnt = mc;
`else
        e.cnt = '0;
`endif
        q.push_back(e);
        @(posedge CLK);
        #1;
        e = q.pop_front();
        check("regs", 192'(obs()), 192'(e.s));
        check("bubble_count", 192'(bubble_count_out), 192'(e.cnt));
        m = e.s;
        mc = e.cnt;
    endtask

    initial begin
        st_t d, snap;

        // 1: reset with every input high
        d = '1;
        step(d, 1'b1, 1'b1, 1'b1, 1'b0);
        step(d, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset_valid", 192'(valid_out), 192'(0));
        check("reset_hazard", 192'(hazard_stall_out), 192'(0));

        // 2: pass-through
        d = rnd(); d.v = 1; d.pc = 32'h100; d.rd = 5; d.f3 = 3'b010; d.aop = 2'b10; d.rw = 1;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pt_pc", 192'(pc_out), 192'(32'h100));
        check("pt_rd", 192'(instruction_11_7_out), 192'(5));
        check("pt_f3", 192'(instruction_14_12_out), 192'(3'b010));
        check("pt_aop", 192'(alu_op_out), 192'(2'b10));
        check("pt_rw_v", 192'({reg_write_out, valid_out}), 192'(2'b11));

        // 3: load-use on rs2
        d = rnd(); d.v = 1; d.mr = 1; d.rd = 5; d.rw = 1; d.m2r = 1; d.aop = 2'b00;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        d = rnd(); d.v = 1; d.rs1i = 1; d.rs2i = 5; d.rw = 1;
        RESET = 0; stall_in = 0; flush_in = 0; drive(d); #1;
        check("lu_stall", 192'(hazard_stall_out), 192'(1));
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lu_bubble", 192'({valid_out, reg_write_out}), 192'(2'b00));
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lu_resume", 192'(valid_out), 192'(1));

        // 4: load to x0 never stalls
        d = rnd(); d.v = 1; d.mr = 1; d.rd = 0; d.rw = 1;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        d = rnd(); d.v = 1; d.rs1i = 0; d.rs2i = 0;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        check("x0_capture", 192'(valid_out), 192'(1));

        // 5: flush and stall in the same cycle with a store in EX
        d = rnd(); d.v = 1; d.mw = 1; d.asrc = 1;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        step(rnd(), 1'b0, 1'b1, 1'b1, 1'b1);
        check("flush_stall", 192'({valid_out, mem_write_out}), 192'(2'b00));
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("count_two", 192'(bubble_count_out), 192'(2));
`else
        check("count_zero", 192'(bubble_count_out), 192'(0));
`endif

        // 6: hold for 3 cycles with changing inputs
        d = rnd(); d.v = 1; d.br = 1; d.aop = 2'b01;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        snap = obs();
        for (int i = 0; i < 3; i++) begin
            d = rnd(); d.v = 1; d.rw = 1; d.mr = 1;
            step(d, 1'b0, 1'b1, 1'b0, 1'b1);
            check("hold_snap", 192'(obs()), 192'(snap));
        end

        // Saturation of the narrow bubble counter
        for (int i = 0; i < 3; i++) step(rnd(), 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ID_EX_BUBBLE_COUNT_EN
        check("count_sat", 192'(bubble_count_out), 192'(3));
`endif

        // Reset arriving mid-hazard
        d = rnd(); d.v = 1; d.mr = 1; d.rd = 7; d.rw = 1;
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);
        d = rnd(); d.v = 1; d.rs1i = 7;
        step(d, 1'b1, 1'b0, 1'b0, 1'b1);
        RESET = 0; #1;
        check("rst_hz_clear", 192'(hazard_stall_out), 192'(0));
        step(d, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
